// File: rtl/exe_stage.sv
// Execute stage: 1-cycle ALU and branch resolve, iterative MUL/DIVU/REMU; results registered into EX/MEM.
// Latency 1 edge (MC_STEPS+2 edges for multi-cycle ops); stall holds IF, IF/ID and ID/EX while an op iterates.
module exe_stage #(
  parameter int XLEN     = 32,
  parameter int MC_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            wb_en_in,
  input  logic [3:0]      ex_cmd_in,
  input  logic [1:0]      branch_type_in,
  input  logic            mem_write_in,
  input  logic            mem_read_in,
  input  logic [XLEN-1:0] val1_in,
  input  logic [XLEN-1:0] val2_in,
  input  logic [XLEN-1:0] reg2_in,
  input  logic [4:0]      dst_in,
  output logic            stall,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_addr,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] st_val,
  output logic [4:0]      dst,
  output logic            wb_en,
  output logic            mem_write,
  output logic            mem_read
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(MC_STEPS);
  localparam logic [3:0] CMD_MUL  = 4'b1001;
  localparam logic [3:0] CMD_DIVU = 4'b1010;
  localparam logic [3:0] CMD_REMU = 4'b1011;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] acc;
  logic [3:0]      mc_cmd;
  logic            is_mc;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_val;
  logic [XLEN-1:0] mc_val;
  logic [XLEN:0]   div_tmp;
  logic            div_ge;
  logic            br_cond;

  assign is_mc = (ex_cmd_in == CMD_MUL) || (ex_cmd_in == CMD_DIVU) || (ex_cmd_in == CMD_REMU);
  // Gated by rst so an async reset mid-op releases the pipeline even while the op is still presented.
  assign stall = rst && (((state == IDLE) && is_mc) || (state == CALC));
  assign shamt = val2_in[SHW-1:0];

  always_comb begin
    alu_val = '0;
    case (ex_cmd_in)
      4'b0000: alu_val = val1_in + val2_in;
      4'b0001: alu_val = val1_in - val2_in;
      4'b0010: alu_val = val1_in & val2_in;
      4'b0011: alu_val = val1_in | val2_in;
      4'b0100: alu_val = ~(val1_in | val2_in);
      4'b0101: alu_val = val1_in ^ val2_in;
      4'b0110: alu_val = val1_in << shamt;
      4'b0111: alu_val = $unsigned($signed(val1_in) >>> shamt);
      4'b1000: alu_val = val1_in >> shamt;
      default: alu_val = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (branch_type_in)
      2'b01:   br_cond = (val1_in == '0);
      2'b10:   br_cond = (val1_in != reg2_in);
      2'b11:   br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

  assign branch_addr  = pc_in + (val2_in << 2);
  assign branch_taken = br_cond && !stall && !is_mc;

  // Restoring divide: op_a shifts dividend bits out and quotient bits in; acc holds the partial remainder.
  // A zero divisor naturally yields an all-ones quotient and the dividend as remainder.
  assign div_tmp = {acc, op_a[XLEN-1]};
  assign div_ge  = (div_tmp >= {1'b0, op_b});
  assign mc_val  = (mc_cmd == CMD_DIVU) ? op_a : acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      acc        <= '0;
      mc_cmd     <= '0;
      alu_result <= '0;
      st_val     <= '0;
      dst        <= '0;
      wb_en      <= 1'b0;
      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
    end else begin
      alu_result <= '0;
      st_val     <= '0;
      dst        <= '0;
      wb_en      <= 1'b0;
      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
      case (state)
        IDLE: begin
          if (is_mc) begin
            op_a   <= val1_in;
            op_b   <= val2_in;
            acc    <= '0;
            cnt    <= '0;
            mc_cmd <= ex_cmd_in;
            state  <= CALC;
          end else begin
            alu_result <= alu_val;
            st_val     <= reg2_in;
            dst        <= dst_in;
            wb_en      <= wb_en_in;
            mem_write  <= mem_write_in;
            mem_read   <= mem_read_in;
          end
        end
        CALC: begin
          if (mc_cmd == CMD_MUL) begin
            if (op_b[0]) acc <= acc + op_a;
            op_a <= op_a << 1;
            op_b <= op_b >> 1;
          end else begin
            acc  <= div_ge ? (div_tmp[XLEN-1:0] - op_b) : div_tmp[XLEN-1:0];
            op_a <= {op_a[XLEN-2:0], div_ge};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(MC_STEPS - 1)) state <= DONE;
        end
        DONE: begin
          alu_result <= mc_val;
          st_val     <= reg2_in;
          dst        <= dst_in;
          wb_en      <= wb_en_in;
          mem_write  <= mem_write_in;
          mem_read   <= mem_read_in;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed vectors, an arithmetic reference model and a per-cycle compare process.
module tb_exe_stage;
  localparam int STALL_CYC = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in = '0;
  logic        wb_en_in = 1'b0;
  logic [3:0]  ex_cmd_in = '0;
  logic [1:0]  branch_type_in = '0;
  logic        mem_write_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic [31:0] val1_in = '0;
  logic [31:0] val2_in = '0;
  logic [31:0] reg2_in = '0;
  logic [4:0]  dst_in = '0;
  logic        stall, branch_taken, wb_en, mem_write, mem_read;
  logic [31:0] branch_addr, alu_result, st_val;
  logic [4:0]  dst;

  int n_checks = 0;
  int n_fail = 0;

  exe_stage #(.XLEN(32), .MC_STEPS(32)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .wb_en_in(wb_en_in), .ex_cmd_in(ex_cmd_in),
    .branch_type_in(branch_type_in), .mem_write_in(mem_write_in), .mem_read_in(mem_read_in),
    .val1_in(val1_in), .val2_in(val2_in), .reg2_in(reg2_in), .dst_in(dst_in),
    .stall(stall), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .alu_result(alu_result), .st_val(st_val), .dst(dst),
    .wb_en(wb_en), .mem_write(mem_write), .mem_read(mem_read)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_mc_f(input logic [3:0] c);
    return (c == 4'd9) || (c == 4'd10) || (c == 4'd11);
  endfunction

  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return ~(a | b);
      4'd5: return a ^ b;
      4'd6: return a << sh;
      4'd7: return $unsigned($signed(a) >>> sh);
      4'd8: return a >> sh;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mc_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    if (c == 4'd9) return p[31:0];
    if (b == 0) return (c == 4'd10) ? 32'hFFFF_FFFF : a;
    return (c == 4'd10) ? a / b : a % b;
  endfunction

  // Reference model: expected registered outputs and the number of edges spent on a multi-cycle op.
  logic [31:0] e_res = '0;
  logic [31:0] e_st = '0;
  logic [4:0]  e_dst = '0;
  logic        e_wb = 1'b0;
  logic        e_mw = 1'b0;
  logic        e_mr = 1'b0;
  int          mc_cnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_res <= '0; e_st <= '0; e_dst <= '0; e_wb <= 1'b0; e_mw <= 1'b0; e_mr <= 1'b0;
      mc_cnt <= 0;
    end else if (mc_cnt == 0 && !is_mc_f(ex_cmd_in)) begin
      e_res <= alu_f(ex_cmd_in, val1_in, val2_in);
      e_st <= reg2_in; e_dst <= dst_in; e_wb <= wb_en_in; e_mw <= mem_write_in; e_mr <= mem_read_in;
    end else if (mc_cnt < STALL_CYC) begin
      e_res <= '0; e_st <= '0; e_dst <= '0; e_wb <= 1'b0; e_mw <= 1'b0; e_mr <= 1'b0;
      mc_cnt <= mc_cnt + 1;
    end else begin
      e_res <= mc_f(ex_cmd_in, val1_in, val2_in);
      e_st <= reg2_in; e_dst <= dst_in; e_wb <= wb_en_in; e_mw <= mem_write_in; e_mr <= mem_read_in;
      mc_cnt <= 0;
    end
  end

  function automatic logic exp_stall_f();
    return rst && ((mc_cnt == 0 && is_mc_f(ex_cmd_in)) || (mc_cnt >= 1 && mc_cnt < STALL_CYC));
  endfunction

  function automatic logic exp_taken_f();
    logic cond;
    case (branch_type_in)
      2'd1: cond = (val1_in == 0);
      2'd2: cond = (val1_in != reg2_in);
      2'd3: cond = 1'b1;
      default: cond = 1'b0;
    endcase
    return cond && !exp_stall_f() && !is_mc_f(ex_cmd_in);
  endfunction

  always @(negedge clk) begin
    check("stall", {31'd0, stall}, {31'd0, exp_stall_f()});
    check("branch_taken", {31'd0, branch_taken}, {31'd0, exp_taken_f()});
    check("branch_addr", branch_addr, pc_in + (val2_in << 2));
    check("alu_result", alu_result, e_res);
    check("st_val", st_val, e_st);
    check("dst", {27'd0, dst}, {27'd0, e_dst});
    check("wb_en", {31'd0, wb_en}, {31'd0, e_wb});
    check("mem_write", {31'd0, mem_write}, {31'd0, e_mw});
    check("mem_read", {31'd0, mem_read}, {31'd0, e_mr});
  end

  task automatic set_in(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r2, input logic [1:0] bt, input logic wb,
                        input logic mw, input logic mr, input logic [4:0] d, input logic [31:0] pc);
    ex_cmd_in = c; val1_in = a; val2_in = b; reg2_in = r2; branch_type_in = bt;
    wb_en_in = wb; mem_write_in = mw; mem_read_in = mr; dst_in = d; pc_in = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_mc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] bt, input logic [4:0] d, output int n);
    set_in(c, a, b, 32'h0, bt, 1'b1, 1'b0, 1'b0, d, 32'h0);
    #1;
    check("mc_stall_start", {31'd0, stall}, 32'd1);
    check("mc_no_branch", {31'd0, branch_taken}, 32'd0);
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    val1_in = 32'd5;
    repeat (2) @(posedge clk);
    #2;
    check("rst_alu_result", alu_result, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_wb_en", {31'd0, wb_en}, 32'd0);
    rst = 1'b1;
    tick();
    check("post_rst_add", alu_result, 32'd5);

    set_in(4'd1, 32'hF0F0_0000, 32'h4, 32'h55, 2'd0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0); tick();
    check("sub", alu_result, 32'hF0EF_FFFC);
    check("sub_dst", {27'd0, dst}, 32'd3);
    check("sub_wb", {31'd0, wb_en}, 32'd1);
    set_in(4'd7, 32'hF0F0_0000, 32'h4, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd4, 32'h0); tick();
    check("sra", alu_result, 32'hFF0F_0000);
    set_in(4'd8, 32'hF0F0_0000, 32'h4, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h0); tick();
    check("srl", alu_result, 32'h0F0F_0000);
    check("srl_mw", {31'd0, mem_write}, 32'd1);
    set_in(4'd4, 32'hF0F0_0000, 32'h4, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 5'd6, 32'h0); tick();
    check("nor", alu_result, 32'hF0F0_0000 ^ 32'hF0F0_0000 ^ 32'h0F0F_FFFB);
    set_in(4'd6, 32'h0000_0003, 32'h24, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd1, 32'h0); tick();
    check("sll_5bit", alu_result, 32'h0000_0030);
    set_in(4'd5, 32'hAAAA_0000, 32'h0F0F_FFFF, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd2, 32'h0); tick();
    set_in(4'd2, 32'hAAAA_5555, 32'h0F0F_FFFF, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd2, 32'h0); tick();
    set_in(4'd3, 32'hAAAA_5555, 32'h0F0F_0000, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd2, 32'h0); tick();
    set_in(4'd13, 32'h1234_5678, 32'h1, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd2, 32'h0); tick();
    check("undef_cmd", alu_result, 32'd0);
    set_in(4'd0, 32'hFFFF_FFFF, 32'h2, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd9, 32'h0); tick();
    check("add_wrap", alu_result, 32'd1);
    set_in(4'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0); tick();
    check("bubble_wb", {31'd0, wb_en}, 32'd0);

    set_in(4'd0, 32'd0, 32'd3, 32'd9, 2'd1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h100); #1;
    check("bez_taken", {31'd0, branch_taken}, 32'd1);
    check("br_addr", branch_addr, 32'h10C);
    tick();
    set_in(4'd0, 32'd1, 32'd3, 32'd9, 2'd1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h100); #1;
    check("bez_not", {31'd0, branch_taken}, 32'd0);
    tick();
    set_in(4'd0, 32'd7, 32'd3, 32'd7, 2'd2, 1'b0, 1'b0, 1'b0, 5'd0, 32'h100); #1;
    check("bne_not", {31'd0, branch_taken}, 32'd0);
    tick();
    set_in(4'd0, 32'd1, 32'd3, 32'd2, 2'd2, 1'b0, 1'b0, 1'b0, 5'd0, 32'h100); #1;
    check("bne_taken", {31'd0, branch_taken}, 32'd1);
    tick();
    set_in(4'd0, 32'd1, 32'd3, 32'd2, 2'd3, 1'b1, 1'b0, 1'b0, 5'd31, 32'h100); #1;
    check("jmp_taken", {31'd0, branch_taken}, 32'd1);
    tick();
    check("jmp_registers", alu_result, 32'd4);

    run_mc(4'd9, 32'h0001_0003, 32'h5, 2'd0, 5'd7, n);
    check("mul_stall_cycles", n, 32'd33);
    check("mul_result", alu_result, 32'h0005_000F);
    check("mul_dst", {27'd0, dst}, 32'd7);
    check("mul_wb", {31'd0, wb_en}, 32'd1);
    set_in(4'd0, 32'd1, 32'd2, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd8, 32'h0); tick();
    check("after_mul", alu_result, 32'd3);

    run_mc(4'd10, 32'd100, 32'd7, 2'd3, 5'd10, n);
    check("divu_result", alu_result, 32'd14);
    run_mc(4'd11, 32'd100, 32'd7, 2'd0, 5'd11, n);
    check("b2b_stall_cycles", n, 32'd33);
    check("remu_result", alu_result, 32'd2);
    run_mc(4'd10, 32'd9, 32'd0, 2'd0, 5'd12, n);
    check("divu_by0", alu_result, 32'hFFFF_FFFF);
    run_mc(4'd11, 32'd9, 32'd0, 2'd0, 5'd13, n);
    check("remu_by0", alu_result, 32'd9);

    set_in(4'd10, 32'd1000, 32'd33, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd14, 32'h0);
    repeat (11) tick();
    check("mid_calc_stall", {31'd0, stall}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_result", alu_result, 32'd0);
    tick();
    rst = 1'b1;
    run_mc(4'd10, 32'd1000, 32'd33, 2'd0, 5'd14, n);
    check("fresh_stall_cycles", n, 32'd33);
    check("fresh_divu", alu_result, 32'd30);
    run_mc(4'd11, 32'd1000, 32'd33, 2'd0, 5'd15, n);
    check("fresh_remu", alu_result, 32'd10);

    set_in(4'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
